dsp_sram_responder: RTL

//  Memory-side responder for the DSP core's memory stage. Accepts load/store requests (addr bit 15 = bank

---
 rtl/dsp_sram_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dsp_sram_responder.sv
// Memory-stage responder: loads served on two 1-cycle SRAM banks, stores posted in a write buffer.
// Optional macro DSP_MEM_FWD_EN: loads hitting the write buffer are forwarded instead of stalled.
module dsp_sram_responder #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 15,
   parameter int WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [15:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              b1_en,
   output logic              b1_we,
   output logic [ADDR_W-1:0] b1_addr,
   output logic [DATA_W-1:0] b1_wdata,
   input  logic [DATA_W-1:0] b1_rdata,
   output logic              b2_en,
   output logic              b2_we,
   output logic [ADDR_W-1:0] b2_addr,
   output logic [DATA_W-1:0] b2_wdata,
   input  logic [DATA_W-1:0] b2_rdata
);
   localparam int PTR_W = $clog2(WB_DEPTH);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   typedef struct packed {
      logic [15:0]       addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   state_t           state, state_nxt;
   wb_entry_t        wb_mem [WB_DEPTH];
   wb_entry_t        head_ent;
   logic [PTR_W-1:0] head, tail, idx;
   logic [PTR_W:0]   count;
   logic             wb_full, head_bank, ld_bank;
   logic             hit, fwd, hit_stall, full_stall;
   logic [DATA_W-1:0] hit_data;
   logic             run, ld_acc, ld_sram, st_acc, drain;
   logic             rsp_vld_q, rsp_fwd_q, rsp_bank_q;
   logic [DATA_W-1:0] fwd_data_q;

   assign head_ent  = wb_mem[head];
   assign head_bank = head_ent.addr[15];
   assign ld_bank   = req_addr[15];
   assign wb_full   = (count == (PTR_W+1)'(WB_DEPTH));

   // Walk oldest to youngest so the youngest matching entry is the one that sticks.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (((PTR_W+1)'(i) < count) && (wb_mem[idx].addr == req_addr)) begin
            hit      = 1'b1;
            hit_data = wb_mem[idx].data;
         end
      end
   end

`ifdef DSP_MEM_FWD_EN
   assign fwd       = hit;
   assign hit_stall = 1'b0;
`else
   assign fwd       = 1'b0;
   assign hit_stall = hit;
`endif

   // A full buffer must not be starved by loads to the bank its head is waiting on.
   assign full_stall = wb_full && (ld_bank == head_bank);
   assign run        = (state == RUN) && !rst;
   assign req_ready  = run && (req_write ? !wb_full : !(full_stall || hit_stall));
   assign ld_acc     = req_valid && !req_write && req_ready;
   assign st_acc     = req_valid && req_write && req_ready;
   assign ld_sram    = ld_acc && !fwd;
   assign drain      = !rst && (count != '0) && !(ld_sram && (ld_bank == head_bank));

   always_comb begin
      b1_en    = 1'b0;
      b1_we    = 1'b0;
      b1_addr  = '0;
      b1_wdata = '0;
      b2_en    = 1'b0;
      b2_we    = 1'b0;
      b2_addr  = '0;
      b2_wdata = '0;
      if (ld_sram) begin
         if (ld_bank) begin
            b2_en   = 1'b1;
            b2_addr = req_addr[ADDR_W-1:0];
         end else begin
            b1_en   = 1'b1;
            b1_addr = req_addr[ADDR_W-1:0];
         end
      end
      if (drain) begin
         if (head_bank) begin
            b2_en    = 1'b1;
            b2_we    = 1'b1;
            b2_addr  = head_ent.addr[ADDR_W-1:0];
            b2_wdata = head_ent.data;
         end else begin
            b1_en    = 1'b1;
            b1_we    = 1'b1;
            b1_addr  = head_ent.addr[ADDR_W-1:0];
            b1_wdata = head_ent.data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush_req) state_nxt = FLUSH;
         FLUSH:   if ((count == '0) && !drain) state_nxt = DONE;
         DONE:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Entry storage needs no reset; count/pointers define what is live.
   always_ff @(posedge clk) begin
      if (st_acc) wb_mem[tail] <= '{addr: req_addr, data: req_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_fwd_q  <= 1'b0;
         rsp_bank_q <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         state      <= state_nxt;
         if (st_acc) tail <= tail + 1'b1;
         if (drain)  head <= head + 1'b1;
         count      <= count + (PTR_W+1)'(st_acc) - (PTR_W+1)'(drain);
         rsp_vld_q  <= ld_acc;
         rsp_fwd_q  <= ld_acc && fwd;
         rsp_bank_q <= ld_bank;
         fwd_data_q <= hit_data;
      end
   end

   assign rsp_valid  = rsp_vld_q && !rst;
   assign rsp_rdata  = !rsp_valid ? '0 :
                       rsp_fwd_q  ? fwd_data_q :
                       rsp_bank_q ? b2_rdata : b1_rdata;
   assign flush_done = (state == DONE) && !rst;
endmodule
